// File: rtl/alpha_uart_tx_pkg.sv
// alpha_uart_tx shared definitions: ASCII codes,
// FSM encodings and frame geometry.
package alpha_uart_tx_pkg;

  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_B  = 8'h62;
  localparam logic [7:0] ASCII_C  = 8'h63;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/alpha_uart_tx_fifo.sv
// alpha_fifo: small synchronous character FIFO.
// Read data is registered on pop; a push into a full FIFO is taken only with a pop.
module alpha_fifo
  import alpha_uart_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // storage array, written on every accepted push
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  // pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) begin
        rptr  <= rptr + AW'(1);
        rdata <= mem[rptr];
      end
      if (wr_en && !rd_en)      count <= count + (AW+1)'(1);
      else if (rd_en && !wr_en) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alpha_uart_tx.sv
// alpha_uart_tx: buffered 8N1 transmitter for classifier result characters.
// Define ALPHA_TX_NEWLINE_EN to follow each character with CR LF frames.
module alpha_uart_tx
  import alpha_uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_valid,
  input  logic [7:0]                    i_alpha,
  output logic                          o_txd,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    tx_byte;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          last_frame;
  logic          pop;

`ifdef ALPHA_TX_NEWLINE_EN
  logic [1:0] sfx;
  assign tx_byte = (sfx == 2'd0) ? fifo_rdata :
                   (sfx == 2'd1) ? ASCII_CR : ASCII_LF;
  assign last_frame = (sfx == 2'd2);
`else
  assign tx_byte    = fifo_rdata;
  assign last_frame = 1'b1;
`endif

  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_STOP && cnt == '0 && last_frame));

  assign o_busy = (state != ST_IDLE) || !fifo_empty;

  alpha_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (i_valid),
    .pop     (pop),
    .wdata   (i_alpha),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  // flag a character dropped against a full, non-draining FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_overflow <= 1'b0;
    else          o_overflow <= i_valid && fifo_full && !pop;
  end

  // frame sequencer: baud counter, bit index, shift register and line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= 8'hFF;
      o_txd   <= 1'b1;
`ifdef ALPHA_TX_NEWLINE_EN
      sfx     <= 2'd0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_START;
            cnt   <= CNT_TOP;
            o_txd <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            state   <= ST_DATA;
            cnt     <= CNT_TOP;
            bit_idx <= '0;
            shift   <= {1'b1, tx_byte[7:1]};
            o_txd   <= tx_byte[0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_TOP;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              o_txd <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b1, shift[7:1]};
              o_txd   <= shift[0];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (!last_frame || !fifo_empty) begin
              state <= ST_START;
              cnt   <= CNT_TOP;
              o_txd <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
`ifdef ALPHA_TX_NEWLINE_EN
            sfx <= last_frame ? 2'd0 : sfx + 2'd1;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_uart_tx.sv
// tb_alpha_uart_tx: scoreboard bench for alpha_uart_tx.
// A line monitor decodes frames and compares them to queued expectations.
module tb_alpha_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
`ifdef ALPHA_TX_NEWLINE_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif
  localparam int FRAME_CYC = 10 * DIV;
  localparam int CHAR_CYC  = FRAME_CYC * NFR;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_alpha = 8'h00;
  logic       o_txd;
  logic       o_busy;
  logic       o_overflow;
  logic [2:0] o_fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  bit         rx_act = 0;
  int         rx_t = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;
  bit         rx_bad;
  bit         rx_stray;

  alpha_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_alpha      (i_alpha),
    .o_txd        (o_txd),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // line monitor: every cycle of a frame is compared to the expected level
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (o_txd === 1'b0) begin
        rx_act = 1;
        rx_t = 0;
        rx_bad = 0;
        rx_byte = 8'h00;
        starts.push_back(cyc);
        rx_stray = (exp_q.size() == 0);
        rx_exp = rx_stray ? 8'h00 : exp_q[0];
      end
    end else begin
      int pos;
      logic lvl;
      rx_t++;
      pos = rx_t / DIV;
      if (pos == 0)      lvl = 1'b0;
      else if (pos == 9) lvl = 1'b1;
      else               lvl = rx_exp[pos-1];
      if (o_txd !== lvl) rx_bad = 1;
      if (pos >= 1 && pos <= 8 && (rx_t % DIV) == DIV/2)
        rx_byte[pos-1] = o_txd;
      if (rx_t == FRAME_CYC - 1) begin
        checks++;
        if (rx_stray) begin
          errors++;
          $display("FAIL frame: unexpected frame got %02h", rx_byte);
        end else begin
          void'(exp_q.pop_front());
          if (rx_bad || rx_byte !== rx_exp) begin
            errors++;
            $display("FAIL frame: got %02h expected %02h (bad=%0d)",
                     rx_byte, rx_exp, rx_bad);
          end
        end
        rx_act = 0;
      end
    end
  end

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef ALPHA_TX_NEWLINE_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // one-cycle strobe, sampled by the next rising edge
  task automatic send(input logic [7:0] b);
    i_valid = 1'b1;
    i_alpha = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || rx_act) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles", tag, o_busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d frames left expected 0",
               tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (o_txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd: got %b expected 1", o_txd);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", o_overflow);
    end
    checks++;
    if (o_fifo_count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", o_fifo_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single(input logic [7:0] b, input string tag);
    int e0;
    starts.delete();
    push_exp(b);
    send(b);
    e0 = cyc;
    checks++;
    if (o_fifo_count !== 3'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_e0: got count=%0d busy=%b expected 1 1",
               tag, o_fifo_count, o_busy);
    end
    checks++;
    if (o_txd !== 1'b1) begin
      errors++; $display("FAIL %s_txd_e0: got %b expected 1", tag, o_txd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_txd !== 1'b0) begin
      errors++; $display("FAIL %s_start_e1: got %b expected 0", tag, o_txd);
    end
    repeat (CHAR_CYC - 1) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy_last: got %b expected 1", tag, o_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy_fall: got %b expected 0", tag, o_busy);
    end
    wait_idle(tag);
    checks++;
    if (starts.size() != NFR || starts[0] != e0 + 1) begin
      errors++;
      $display("FAIL %s_starts: got n=%0d first=%0d expected n=%0d first=%0d",
               tag, starts.size(), starts.size() ? starts[0] : -1, NFR, e0 + 1);
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != FRAME_CYC) begin
        errors++;
        $display("FAIL %s_gap: got %0d expected %0d",
                 tag, starts[i] - starts[i-1], FRAME_CYC);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] chars [3];
    chars[0] = 8'h61;
    chars[1] = 8'h62;
    chars[2] = 8'h63;
    starts.delete();
    for (int i = 0; i < 3; i++) begin
      push_exp(chars[i]);
      send(chars[i]);
    end
    wait_idle("b2b");
    checks++;
    if (starts.size() != 3 * NFR) begin
      errors++;
      $display("FAIL b2b_frames: got %0d expected %0d", starts.size(), 3 * NFR);
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != FRAME_CYC) begin
        errors++;
        $display("FAIL b2b_gap: got %0d expected %0d",
                 starts[i] - starts[i-1], FRAME_CYC);
      end
    end
  endtask

  task automatic test_overflow();
    int cnt_exp [6];
    cnt_exp[0] = 1; cnt_exp[1] = 1; cnt_exp[2] = 2;
    cnt_exp[3] = 3; cnt_exp[4] = 4; cnt_exp[5] = 4;
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_exp(8'h30 + 8'(i));
      send(8'h30 + 8'(i));
      checks++;
      if (o_overflow !== (i == 5)) begin
        errors++;
        $display("FAIL ovf_pulse%0d: got %b expected %b", i, o_overflow, i == 5);
      end
      checks++;
      if (o_fifo_count !== 3'(cnt_exp[i])) begin
        errors++;
        $display("FAIL ovf_count%0d: got %0d expected %0d",
                 i, o_fifo_count, cnt_exp[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_single: got %b expected 0", o_overflow);
    end
    wait_idle("ovf");
    checks++;
    if (starts.size() != 5 * NFR) begin
      errors++;
      $display("FAIL ovf_frames: got %0d expected %0d", starts.size(), 5 * NFR);
    end
  endtask

  task automatic test_full_pop();
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      push_exp(8'h41 + 8'(i));
      send(8'h41 + 8'(i));
    end
    repeat (CHAR_CYC - 4) @(posedge clk);
    #1;
    checks++;
    if (o_fifo_count !== 3'd4) begin
      errors++; $display("FAIL fp_pre_count: got %0d expected 4", o_fifo_count);
    end
    push_exp(8'h5A);
    send(8'h5A);
    checks++;
    if (o_fifo_count !== 3'd4) begin
      errors++; $display("FAIL fp_count: got %0d expected 4", o_fifo_count);
    end
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL fp_ovf0: got %b expected 0", o_overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL fp_ovf1: got %b expected 0", o_overflow);
    end
    wait_idle("fp");
    checks++;
    if (starts.size() != 6 * NFR) begin
      errors++;
      $display("FAIL fp_frames: got %0d expected %0d", starts.size(), 6 * NFR);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    send(8'h63);
    send(8'h61);
    repeat (44) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_txd !== 1'b1 || o_fifo_count !== 3'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid: got txd=%b count=%0d busy=%b expected 1 0 0",
               o_txd, o_fifo_count, o_busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (o_txd !== 1'b1 || o_busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL rstmid_idle: got activity expected idle line");
    end
    @(posedge clk);
    #1;
    test_single(8'h62, "rstmid_new");
  endtask

  initial begin
    test_reset();
    test_single(8'h61, "single");
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef ALPHA_TX_NEWLINE_EN
    test_single(8'h62, "newline");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
